prm_edge_scan_ctrl: RTL
=======================

PRM_EDGE_SCAN_CTRL -- requirements
Module: prm_edge_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_EDGES, default 1024: number of edge-check units scanned; multiple of 32, at most 1024.
REQ-002 SHALL have parameter IDX_W, default 10: edge index width, with 2**IDX_W >= NUM_EDGES.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a scan; ignored while busy.
REQ-006 SHALL have port abort, input, 1: cancels an active scan.
REQ-007 SHALL have port obs_cfg, input, 15: obstacle/config vector; bit 0 = A through bit 14 = O.
REQ-008 SHALL have port chk_vec, output, 15: registered copy of obs_cfg driven to the check bank.
REQ-009 SHALL have port chk_idx, output, IDX_W: selects the edge-check unit.
REQ-010 SHALL have port chk_mask, input, 1: edge_mask of the selected unit; combinational in chk_idx/chk_vec, same cycle.
REQ-011 SHALL have port wr_valid, output, 1: bitmap word available.
REQ-012 SHALL have port wr_ready, input, 1: bitmap RAM accepts the word.
REQ-013 SHALL have port wr_addr, output, IDX_W-5: bitmap word address.
REQ-014 SHALL have port wr_data, output, 32: mask bits; bit k = edge wr_addr*32+k.
REQ-015 SHALL have port busy, output, 1: scan in progress.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at normal completion.
REQ-017 SHALL have port mask_cnt, output, IDX_W+1: number of masked edges in the last scan.

Function
REQ-018 SHALL implement FSM with states IDLE, SCAN, DRAIN, FINISH.
- IDLE -> SCAN on start: latch obs_cfg into chk_vec; clear chk_idx, the shift word and mask_cnt.
REQ-019 In SCAN, each non-stalled cycle SHALL sample chk_mask into shift-word bit chk_idx[4:0], add it to mask_cnt, and increment chk_idx.
REQ-020 When bit 31 is sampled, SHALL move the word to the output holding register (wr_valid=1, wr_addr=chk_idx[IDX_W-1:5]) in the next cycle.
REQ-021 SHALL stall SCAN (chk_idx and word frozen) only when a completed word must enter the holding register while it is still valid and wr_ready=0.
REQ-022 A transfer SHALL occur when wr_valid&wr_ready; wr_data/wr_addr SHALL stay stable while wr_valid=1 and wr_ready=0.
REQ-023 After edge NUM_EDGES-1 is sampled, SHALL go SCAN -> DRAIN; DRAIN -> FINISH when the last word has transferred.
REQ-024 FINISH SHALL pulse done for one cycle, then return to IDLE; busy=1 in SCAN and DRAIN only.
REQ-025 Minimum scan latency with wr_ready held 1 SHALL be NUM_EDGES+2 cycles from start to done.
REQ-026 abort in SCAN or DRAIN SHALL go to IDLE next cycle: wr_valid cleared, no done, mask_cnt holds its partial value.
- abort and start in the same cycle while IDLE: start wins.
REQ-027 chk_idx SHALL not wrap; NUM_EDGES-1 is the last index issued.
REQ-028 mask_cnt SHALL hold its value in IDLE until the next start.

Reset
REQ-029 rst_n low SHALL force IDLE, chk_idx=0, chk_vec=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, mask_cnt=0.
- Asserting rst_n mid-scan SHALL discard all partial results.

Structure
REQ-030 A shared package prm_pkg SHALL hold the FSM state enum, CFG_W=15 and WORD_W=32.
REQ-031 The 32-bit word packer plus holding register SHALL be a sub-module prm_mask_packer; the check-unit mux stays outside this block.

Verification
REQ-032 NUM_EDGES=64, chk_mask=1 for every edge, wr_ready=1 -> two writes of 0xFFFFFFFF at addr 0,1; mask_cnt=64; done at cycle 66.
REQ-033 chk_mask = chk_idx[0] -> wr_data=0xAAAAAAAA in every word; mask_cnt=NUM_EDGES/2.
REQ-034 wr_ready=0 for 40 cycles after the first word -> scan stalls at idx 63; word 0 held stable; no lost or duplicated word.
REQ-035 abort at idx 20 -> IDLE next cycle, no done, no write, mask_cnt = masked count of idx 0..19.
REQ-036 rst_n low at idx 33 while wr_valid=1 -> all outputs at reset values immediately; a new start runs a clean scan.
REQ-037 start pulsed during busy -> ignored; chk_vec unchanged from the value latched at the first start.

Source files
------------

// File: rtl/prm_pkg.sv
// ----------------------------------------------------------------------------
// prm_pkg
// Shared definitions for the edge-scan controller slice.
//   CFG_W    : width of the obstacle/config vector driven to the check bank
//   WORD_W   : width of one bitmap word written to RAM
//   BIT_W    : bit-position width inside one bitmap word
//   prm_state_e : scan controller FSM states
// ----------------------------------------------------------------------------
package prm_pkg;

    localparam int unsigned CFG_W  = 15;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BIT_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } prm_state_e;

endpackage

// File: rtl/prm_mask_packer.sv
// ----------------------------------------------------------------------------
// prm_mask_packer
// Packs one mask bit per accepted sample into a 32-bit word and hands each
// completed word to a valid/ready holding register.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_clear       : clears the partial word (start of a new scan)
//   i_req         : a sample is requested this cycle
//   i_flush       : drops any word waiting in the holding register
//   i_bit         : mask bit to store
//   i_bit_idx     : bit position of i_bit inside the word
//   i_word_addr   : word address recorded when the word completes
//   i_wr_ready    : downstream accepts the held word
//   o_take        : the requested sample is accepted this cycle
//   o_stall       : the requested sample is held off this cycle
//   o_wr_valid/o_wr_addr/o_wr_data : holding register
// ----------------------------------------------------------------------------
module prm_mask_packer
    import prm_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_req,
    input  logic              i_flush,
    input  logic              i_bit,
    input  logic [BIT_W-1:0]  i_bit_idx,
    input  logic [ADDR_W-1:0] i_word_addr,
    input  logic              i_wr_ready,
    output logic              o_take,
    output logic              o_stall,
    output logic              o_wr_valid,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WORD_W-1:0] o_wr_data
);

    // Bit 31 is never stored: it goes straight into the holding register
    // together with the 31 bits gathered so far.
    logic [WORD_W-2:0] r_shift;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;

    logic w_last_bit;
    logic w_out_free;
    logic w_load;

    assign w_last_bit = (i_bit_idx == BIT_W'(WORD_W - 1));
    // Holding register can take a new word if empty or emptying this cycle.
    assign w_out_free = !r_valid || i_wr_ready;
    assign o_stall    = i_req && w_last_bit && !w_out_free;
    assign o_take     = i_req && !o_stall;
    assign w_load     = o_take && w_last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
        end else if (o_take && !w_last_bit) begin
            r_shift[i_bit_idx] <= i_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_word_addr;
            r_data  <= {i_bit, r_shift};
        end else if (r_valid && i_wr_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_wr_valid = r_valid;
    assign o_wr_addr  = r_addr;
    assign o_wr_data  = r_data;

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// ----------------------------------------------------------------------------
// prm_edge_scan_ctrl
// Walks every edge-check unit once per scan, collects each unit's edge_mask
// into 32-bit bitmap words for RAM and counts masked edges.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begins a scan (ignored unless idle)
//   abort      : cancels an active scan
//   obs_cfg    : obstacle/config vector, latched at start into chk_vec
//   chk_vec    : config vector driven to the check bank
//   chk_idx    : selected edge-check unit
//   chk_mask   : edge_mask of the selected unit (same cycle)
//   wr_valid/wr_ready/wr_addr/wr_data : bitmap word write port
//   busy       : scan in progress
//   done       : one-cycle pulse at normal completion
//   mask_cnt   : masked edges counted in the last scan
// ----------------------------------------------------------------------------
module prm_edge_scan_ctrl
    import prm_pkg::*;
#(
    parameter int unsigned NUM_EDGES = 1024,
    parameter int unsigned IDX_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CFG_W-1:0]  obs_cfg,
    output logic [CFG_W-1:0]  chk_vec,
    output logic [IDX_W-1:0]  chk_idx,
    input  logic              chk_mask,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [IDX_W-6:0]  wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [IDX_W:0]    mask_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EDGES - 1);

    prm_state_e r_state;
    prm_state_e w_state_nxt;

    logic [CFG_W-1:0] r_chk_vec;
    logic [IDX_W-1:0] r_chk_idx;
    logic [IDX_W:0]   r_mask_cnt;

    logic w_start_acc;
    logic w_scan_req;
    logic w_flush;
    logic w_take;
    logic w_stall;
    logic w_last_take;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last_take = w_take && (r_chk_idx == LAST_IDX);

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (abort)            w_state_nxt = IDLE;
                else if (w_last_take) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)                      w_state_nxt = IDLE;
                else if (!wr_valid || wr_ready) w_state_nxt = FINISH;
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_start_acc = 1'b0;
        w_scan_req  = 1'b0;
        w_flush     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_acc = start;
            end
            SCAN: begin
                // An aborted cycle samples nothing so mask_cnt keeps the
                // count of edges already scanned.
                w_scan_req = !abort;
                w_flush    = abort;
                busy       = 1'b1;
            end
            DRAIN: begin
                w_flush = abort;
                busy    = 1'b1;
            end
            FINISH: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ---------------- index, config and mask counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_vec  <= '0;
            r_chk_idx  <= '0;
            r_mask_cnt <= '0;
        end else if (w_start_acc) begin
            r_chk_vec  <= obs_cfg;
            r_chk_idx  <= '0;
            r_mask_cnt <= '0;
        end else if (w_take) begin
            r_mask_cnt <= r_mask_cnt + (IDX_W+1)'(chk_mask);
            // Index parks on the last edge instead of wrapping.
            if (r_chk_idx != LAST_IDX) begin
                r_chk_idx <= r_chk_idx + 1'b1;
            end
        end
    end

    prm_mask_packer #(
        .ADDR_W (IDX_W - 5)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_start_acc),
        .i_req       (w_scan_req),
        .i_flush     (w_flush),
        .i_bit       (chk_mask),
        .i_bit_idx   (r_chk_idx[BIT_W-1:0]),
        .i_word_addr (r_chk_idx[IDX_W-1:BIT_W]),
        .i_wr_ready  (wr_ready),
        .o_take      (w_take),
        .o_stall     (w_stall),
        .o_wr_valid  (wr_valid),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data)
    );

    assign chk_vec  = r_chk_vec;
    assign chk_idx  = r_chk_idx;
    assign mask_cnt = r_mask_cnt;

    logic w_unused;
    assign w_unused = w_stall;

endmodule
